// File: rtl/booth_mac_acc.sv
// Accumulator stage behind the pipelined Booth multiplier. It tracks issued operand pairs
// with a latency-matched valid delay line and sums LEN products into a saturating accumulator.
module booth_mac_acc #(
    parameter int WIDTH     = 8,
    parameter int MUL_LAT   = WIDTH + 1,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   mul2acc,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state;
    logic [MUL_LAT-1:0]   vld_sr;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     issued;
    logic [LEN_W-1:0]     retired;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 issue;
    logic                 retire;

    assign in_ready = (state == ACCUM) && (issued < len_q);
    assign issue    = in_valid & in_ready;
    assign retire   = vld_sr[MUL_LAT-1];
    assign acc_out  = acc;

    // One spare bit catches the carry out of the add; it is the saturation flag.
    assign sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, mul2acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            vld_sr    <= '0;
            len_q     <= '0;
            issued    <= '0;
            retired   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading last cycle's values,
            // so the shift and the FSM below see a consistent snapshot regardless of order.
            vld_sr <= (vld_sr << 1) | MUL_LAT'(issue);
            if (issue)
                issued <= issued + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        ovf     <= 1'b0;
                        len_q   <= len;
                        issued  <= '0;
                        retired <= '0;
                        busy    <= 1'b1;
                        if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (retire) begin
                        acc     <= sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
                        retired <= retired + 1'b1;
                        if (sum[ACC_WIDTH])
                            ovf <= 1'b1;
                        if (retired + 1'b1 == len_q) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Randomized bench for booth_mac_acc: a behavioural multiplier pipeline feeds two instances
// (24-bit and 18-bit accumulators); results are checked against a plain-arithmetic job model.
module tb_booth_mac_acc;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;
    localparam int LEN_W = 8;
    localparam longint MAX24 = (64'd1 << 24) - 1;
    localparam longint MAX18 = (64'd1 << 18) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [7:0]       op_a = '0;
    logic [7:0]       op_b = '0;
    logic [15:0]      mul2acc;
    logic [15:0]      mpipe [LAT];

    logic        in_ready, out_valid, ovf, busy;
    logic [23:0] acc_out;
    logic        in_ready18, out_valid18, ovf18, busy18;
    logic [17:0] acc_out18;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int unsigned opa [256];
    int unsigned opb [256];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream multiplier: fixed LAT-cycle pipeline, no valid, shares the reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= 16'(op_a) * 16'(op_b);
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul2acc = mpipe[LAT-1];

    booth_mac_acc #(.WIDTH(WIDTH), .ACC_WIDTH(24), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready), .mul2acc(mul2acc), .acc_out(acc_out), .out_valid(out_valid),
        .out_ready(out_ready), .ovf(ovf), .busy(busy)
    );

    booth_mac_acc #(.WIDTH(WIDTH), .ACC_WIDTH(18), .LEN_W(LEN_W)) dut18 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready18), .mul2acc(mul2acc), .acc_out(acc_out18), .out_valid(out_valid18),
        .out_ready(out_ready), .ovf(ovf18), .busy(busy18)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One job: L products, gap idle cycles between pulses (gap<0: random bubbles),
    // hold cycles with out_ready low in DONE (hold<0: random 0..5).
    task automatic run_job(input int L, input int gap, input int hold);
        longint total = 0;
        longint e24, e18;
        int n = 0, g = 0, last_n = 0, start_cyc, waited, h;
        bit v;

        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        start = 1'b1;
        len = LEN_W'(L);
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        len = LEN_W'($urandom_range(0, 255));

        while (n < L) begin
            v = (gap < 0) ? ($urandom_range(0, 2) != 0) : (g == 0);
            in_valid = v;
            op_a = 8'(opa[n]);
            op_b = 8'(opb[n]);
            check("in_ready_hi", in_ready, 1);
            check("in_ready_hi18", in_ready18, 1);
            if (v) begin
                total += longint'(opa[n]) * longint'(opb[n]);
                last_n = cyc;
                n++;
                g = gap;
            end else if (g > 0) begin
                g--;
            end
            @(negedge clk);
        end

        // Extra in_valid after the last issue must be ignored.
        in_valid = 1'b1;
        op_a = 8'($urandom_range(0, 255));
        op_b = 8'($urandom_range(0, 255));
        waited = 0;
        while (!out_valid && waited < 400) begin
            check("in_ready_lo", in_ready, 0);
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;

        e24 = (total > MAX24) ? MAX24 : total;
        e18 = (total > MAX18) ? MAX18 : total;
        check("out_valid_seen", out_valid, 1);
        check("out_valid18", out_valid18, 1);
        check("latency", cyc, (L == 0) ? start_cyc + 1 : last_n + LAT + 1);
        check("acc24", acc_out, e24);
        check("ovf24", ovf, (total > MAX24) ? 1 : 0);
        check("acc18", acc_out18, e18);
        check("ovf18", ovf18, (total > MAX18) ? 1 : 0);
        check("done_in_ready", in_ready, 0);

        if (hold < 0) hold = $urandom_range(0, 5);
        for (h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start = (h == 1);
            @(negedge clk);
            start = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_busy", busy, 1);
            check("hold_acc24", acc_out, e24);
            check("hold_acc18", acc_out18, e18);
            check("hold_ovf18", ovf18, (total > MAX18) ? 1 : 0);
        end

        // start in the handshake cycle must not launch a job.
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_busy18", busy18, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_acc", acc_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        opa[0] = 3;   opb[0] = 4;
        opa[1] = 5;   opb[1] = 6;
        opa[2] = 255; opb[2] = 255;
        run_job(3, 0, 0);                          // expect 65067

        run_job(0, 0, 1);                          // empty job

        for (int i = 0; i < 5; i++) begin opa[i] = 255; opb[i] = 255; end
        run_job(5, 0, 2);                          // 18-bit saturates

        opa[0] = 9; opb[0] = 9; opa[1] = 10; opb[1] = 11;
        run_job(2, 0, 5);                          // held result, start ignored

        for (int i = 0; i < 4; i++) begin opa[i] = i + 1; opb[i] = i + 1; end
        run_job(4, 2, 1);                          // gapped issues, expect 30

        // Reset after 2 of 4 issues: in-flight products must vanish.
        @(negedge clk);
        start = 1'b1; len = 4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; op_a = 8'd200; op_b = 8'd200;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_acc", acc_out, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", ovf, 0);
        opa[0] = 2; opb[0] = 3;
        run_job(1, 0, 0);                          // expect 6

        for (int i = 0; i < 255; i++) begin opa[i] = 255; opb[i] = 255; end
        run_job(255, 0, 0);                        // maximum length

        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < 256; i++) begin
                opa[i] = $urandom_range(0, 255);
                opb[i] = $urandom_range(0, 255);
            end
            run_job($urandom_range(0, 12), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
